stm_silencer: RTL

STM_SILENCER -- requirements
Module: stm_silencer

---
 rtl/stm_silencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/stm_silencer.sv
// -----------------------------------------------------------------------------
// stm_silencer
// Per-transducer slew limiter sitting behind the stm stage. Each beat carries a
// target intensity/phase for one transducer; the block moves the stored state
// for that transducer toward the target by at most STEP per frame and emits the
// limited value two cycles later. Phase is circular (mod 256) and always takes
// the short way round; an exact half-turn goes negative.
//
// State | Meaning
// ------+----------------------------------------------------------------
// CLEAR | zeroing state memory, one address per cycle; beats are dropped
// RUN   | normal operation, one beat per cycle
//
// Ports
//   clk_i             system clock, rising edge
//   rst_i             synchronous active-high reset
//   update_i          frame-start strobe: restarts beat index, latches steps
//   step_intensity_i  max intensity change per frame
//   step_phase_i      max phase change per frame
//   din_valid_i       input beat valid
//   intensity_i       target intensity
//   phase_i           target phase (mod 256)
//   ready_o           high once the initial memory clear has finished
//   dout_valid_o      output beat valid
//   intensity_o       slew-limited intensity (held between beats)
//   phase_o           slew-limited phase (held between beats)
// -----------------------------------------------------------------------------
module stm_silencer #(
    parameter int DEPTH = 249
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       update_i,
    input  logic [7:0] step_intensity_i,
    input  logic [7:0] step_phase_i,
    input  logic       din_valid_i,
    input  logic [7:0] intensity_i,
    input  logic [7:0] phase_i,
    output logic       ready_o,
    output logic       dout_valid_o,
    output logic [7:0] intensity_o,
    output logic [7:0] phase_o
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    // {intensity, phase} per transducer
    logic [15:0]   mem_q [DEPTH];

    logic [AW-1:0] idx_q, idx_d, idx_base, idx_next;
    logic [7:0]    step_int_q, step_int_d;
    logic [7:0]    step_ph_q, step_ph_d;
    logic          accept;

    logic          s1_valid_q;
    logic [AW-1:0] s1_idx_q;
    logic [7:0]    s1_tgt_int_q, s1_tgt_ph_q;
    logic [7:0]    s1_step_int_q, s1_step_ph_q;
    logic [7:0]    s1_cur_int_q, s1_cur_ph_q;
    logic          fwd;

    logic [7:0]    new_int, new_ph;
    logic [7:0]    int_diff, ph_diff, ph_mag;
    logic          ph_neg;

    logic          dout_valid_q;
    logic [7:0]    int_out_q, ph_out_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == LAST_IDX) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // ------------------------------------------------- beat index, steps
    // A beat arriving with update_i belongs to the new frame, so it sees
    // index 0 and the freshly presented step values.
    always_comb begin
        accept    = din_valid_i && (state_q == ST_RUN);
        idx_base  = update_i ? '0 : idx_q;
        idx_next  = (idx_base == LAST_IDX) ? '0 : idx_base + 1'b1;
        idx_d     = accept ? idx_next : idx_base;
        step_int_d = update_i ? step_intensity_i : step_int_q;
        step_ph_d  = update_i ? step_phase_i     : step_ph_q;
        // stage 2 writes the same entry stage 1 is reading this cycle
        fwd       = s1_valid_q && (s1_idx_q == idx_base);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            step_int_q <= 8'hFF;
            step_ph_q  <= 8'hFF;
        end else begin
            idx_q      <= idx_d;
            step_int_q <= step_int_d;
            step_ph_q  <= step_ph_d;
        end
    end

    // ------------------------------------------------------------ stage 1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q    <= 1'b0;
            s1_idx_q      <= '0;
            s1_tgt_int_q  <= '0;
            s1_tgt_ph_q   <= '0;
            s1_step_int_q <= '0;
            s1_step_ph_q  <= '0;
            s1_cur_int_q  <= '0;
            s1_cur_ph_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_idx_q      <= idx_base;
                s1_tgt_int_q  <= intensity_i;
                s1_tgt_ph_q   <= phase_i;
                s1_step_int_q <= step_int_d;
                s1_step_ph_q  <= step_ph_d;
                if (fwd) begin
                    s1_cur_int_q <= new_int;
                    s1_cur_ph_q  <= new_ph;
                end else begin
                    {s1_cur_int_q, s1_cur_ph_q} <= mem_q[idx_base];
                end
            end
        end
    end

    // ------------------------------------------------------------ stage 2
    always_comb begin
        int_diff = '0;
        if (s1_tgt_int_q >= s1_cur_int_q) begin
            int_diff = s1_tgt_int_q - s1_cur_int_q;
            new_int  = (int_diff <= s1_step_int_q) ? s1_tgt_int_q
                                                   : s1_cur_int_q + s1_step_int_q;
        end else begin
            int_diff = s1_cur_int_q - s1_tgt_int_q;
            new_int  = (int_diff <= s1_step_int_q) ? s1_tgt_int_q
                                                   : s1_cur_int_q - s1_step_int_q;
        end

        // 8-bit wrap of the difference gives the shortest circular path;
        // 0x80 reads as -128 and therefore steps downward.
        ph_diff = s1_tgt_ph_q - s1_cur_ph_q;
        ph_neg  = ph_diff[7];
        ph_mag  = ph_neg ? (8'd0 - ph_diff) : ph_diff;
        if (ph_mag <= s1_step_ph_q) begin
            new_ph = s1_tgt_ph_q;
        end else if (ph_neg) begin
            new_ph = s1_cur_ph_q - s1_step_ph_q;
        end else begin
            new_ph = s1_cur_ph_q + s1_step_ph_q;
        end
    end

    // Single write port: the clear sweep and stage 2 never overlap because
    // no beat is accepted until the sweep has finished.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_addr_q] <= '0;
            end else if (s1_valid_q) begin
                mem_q[s1_idx_q] <= {new_int, new_ph};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_valid_q <= 1'b0;
            int_out_q    <= '0;
            ph_out_q     <= '0;
        end else begin
            dout_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                int_out_q <= new_int;
                ph_out_q  <= new_ph;
            end
        end
    end

    assign ready_o      = (state_q == ST_RUN);
    assign dout_valid_o = dout_valid_q;
    assign intensity_o  = int_out_q;
    assign phase_o      = ph_out_q;

endmodule
